// File: rtl/icache_miss_ctrl.sv
// ============================================================================
// icache_miss_ctrl : instruction-cache line-miss request/fill sequencer
// Optional statistics outputs enabled by ICACHE_MISS_STATS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_miss_ctrl #(
  parameter int LINE_BITS   = 256,
  parameter int TAG_BITS    = 21,
  parameter int INDEX_BITS  = 5,
  parameter int OFFSET_BITS = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_i,
  input  logic                  miss_i,
  input  logic [31:0]           miss_addr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic [31:0]           mem_addr0_o,
  output logic                  mem_re0_o,
  input  logic [LINE_BITS-1:0]  mem_data0_i,
  input  logic                  mem_data_ready0_i,
  input  logic [TAG_BITS-1:0]   mem_tag0_i,
  input  logic [INDEX_BITS-1:0] mem_index0_i,
  output logic                  fill_valid_o,
  output logic [LINE_BITS-1:0]  fill_data_o,
  output logic [TAG_BITS-1:0]   fill_tag_o,
  output logic [INDEX_BITS-1:0] fill_index_o,
  output logic                  err_o
`ifdef ICACHE_MISS_STATS_EN
  ,
  output logic [31:0]           miss_count_o,
  output logic [31:0]           stall_cycles_o
`endif
);

  localparam int          c_IDX_LSB    = OFFSET_BITS + 3;
  localparam int          c_TAG_LSB    = INDEX_BITS + OFFSET_BITS + 3;
  localparam logic [31:0] c_ALIGN_MASK = ~((32'd1 << c_IDX_LSB) - 32'd1);
  localparam logic [7:0]  c_TIMEOUT    = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_addr, w_addr_nxt;
  logic                  r_kill, w_kill_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_capture;
  logic                  w_kill_any;
  logic                  w_match;
  logic [7:0]            w_cnt_inc;
  logic [LINE_BITS-1:0]  r_fdata;
  logic [TAG_BITS-1:0]   r_ftag;
  logic [INDEX_BITS-1:0] r_findex;

  assign w_kill_any = r_kill | flush_i;
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_match    = (mem_tag0_i == r_addr[c_TAG_LSB +: TAG_BITS]) &&
                      (mem_index0_i == r_addr[c_IDX_LSB +: INDEX_BITS]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_kill   <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_fdata  <= '0;
      r_ftag   <= '0;
      r_findex <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_kill  <= w_kill_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_fdata  <= mem_data0_i;
        r_ftag   <= mem_tag0_i;
        r_findex <= mem_index0_i;
      end
    end
  end

  // Everything holds while run_i is low, so a frozen REQ/FILL strobes once on resume.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_kill_nxt  = r_kill;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_capture   = 1'b0;
    if (run_i) begin
      case (r_state)
        S_IDLE: begin
          if (miss_i) begin
            w_state_nxt = S_REQ;
            w_addr_nxt  = miss_addr_i & c_ALIGN_MASK;
          end
        end
        S_REQ: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
          w_kill_nxt  = w_kill_any;
        end
        S_WAIT: begin
          w_cnt_nxt  = w_cnt_inc;
          w_kill_nxt = w_kill_any;
          if (mem_data_ready0_i) begin
            if (w_kill_any) begin
              w_state_nxt = S_IDLE;
              w_kill_nxt  = 1'b0;
            end else if (!w_match) begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_FILL;
              w_capture   = 1'b1;
            end
          end else if (w_cnt_inc == c_TIMEOUT) begin
            // A killed miss is abandoned at timeout instead of re-issued.
            if (w_kill_any) begin
              w_state_nxt = S_IDLE;
              w_kill_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_REQ;
            end
          end
        end
        S_FILL: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy_o       = (r_state != S_IDLE);
  assign mem_re0_o    = (r_state == S_REQ) && run_i;
  assign fill_valid_o = (r_state == S_FILL) && run_i;
  assign mem_addr0_o  = busy_o ? r_addr : 32'd0;
  assign fill_data_o  = r_fdata;
  assign fill_tag_o   = r_ftag;
  assign fill_index_o = r_findex;
  assign err_o        = r_err;

`ifdef ICACHE_MISS_STATS_EN
  logic [31:0] r_miss_count;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_miss_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if ((r_state == S_IDLE) && run_i && miss_i)
        r_miss_count <= r_miss_count + 32'd1;
      if (busy_o && run_i)
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign miss_count_o   = r_miss_count;
  assign stall_cycles_o = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_miss_ctrl.sv
// Directed bench for icache_miss_ctrl: cycle-vector table plus multi-cycle sequences.
`default_nettype none

module tb_icache_miss_ctrl;
  localparam int LB = 256;
  localparam int TO = 8;
  localparam logic [31:0]  A  = 32'h0000_1234;
  localparam logic [31:0]  B  = 32'h0000_2468;
  localparam logic [255:0] DA = {8{32'hA5A5_0001}};
  localparam logic [255:0] DB = {8{32'h5A5A_0002}};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run_i = 1'b1, miss_i = 1'b0, flush_i = 1'b0;
  logic [31:0]   miss_addr_i = '0;
  logic          busy_o, mem_re0_o, fill_valid_o, err_o;
  logic [31:0]   mem_addr0_o;
  logic [LB-1:0] mem_data0_i = '0, fill_data_o;
  logic          mem_data_ready0_i = 1'b0;
  logic [20:0]   mem_tag0_i = '0, fill_tag_o;
  logic [4:0]    mem_index0_i = '0, fill_index_o;
`ifdef ICACHE_MISS_STATS_EN
  logic [31:0]   miss_count_o, stall_cycles_o;
`endif

  icache_miss_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .miss_i(miss_i),
    .miss_addr_i(miss_addr_i), .flush_i(flush_i), .busy_o(busy_o),
    .mem_addr0_o(mem_addr0_o), .mem_re0_o(mem_re0_o),
    .mem_data0_i(mem_data0_i), .mem_data_ready0_i(mem_data_ready0_i),
    .mem_tag0_i(mem_tag0_i), .mem_index0_i(mem_index0_i),
    .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o),
    .fill_tag_o(fill_tag_o), .fill_index_o(fill_index_o), .err_o(err_o)
`ifdef ICACHE_MISS_STATS_EN
    , .miss_count_o(miss_count_o), .stall_cycles_o(stall_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         miss;
    logic [31:0]  addr;
    logic         flush, ready;
    logic [20:0]  rtag;
    logic [4:0]   ridx;
    logic [255:0] rdata;
    logic         busy, re, fill, err;
    logic [31:0]  maddr;
    logic [20:0]  ftag;
    logic [4:0]   fidx;
    logic [255:0] fdata;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic miss, input logic [31:0] addr,
                              input logic flush, input logic ready,
                              input logic [20:0] rtag, input logic [4:0] ridx,
                              input logic [255:0] rdata,
                              input logic busy, input logic re, input logic fill,
                              input logic err, input logic [31:0] maddr,
                              input logic [20:0] ftag, input logic [4:0] fidx,
                              input logic [255:0] fdata);
    vec_t v;
    v.miss = miss; v.addr = addr; v.flush = flush; v.ready = ready;
    v.rtag = rtag; v.ridx = ridx; v.rdata = rdata;
    v.busy = busy; v.re = re; v.fill = fill; v.err = err; v.maddr = maddr;
    v.ftag = ftag; v.fidx = fidx; v.fdata = fdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    miss_i = 1'b0; flush_i = 1'b0; mem_data_ready0_i = 1'b0;
    mem_tag0_i = '0; mem_index0_i = '0; mem_data0_i = '0;
  endtask

  initial begin
    int p1, p2, pulses, fills;

    // A=0x1234 -> line 0x1220, tag 4, index 0x11. B=0x2468 -> line 0x2460, tag 9, index 3.
    //                miss addr fl rdy rtag ridx rdata busy re fill err maddr        ftag fidx fdata
    tbl.push_back(mk(1, A, 0, 0, 0, 0,     0,  0, 0, 0, 0, 32'h0,        0, 0,     0));
    tbl.push_back(mk(1, A, 0, 0, 0, 0,     0,  1, 1, 0, 0, 32'h1220,     0, 0,     0));
    tbl.push_back(mk(1, A, 0, 0, 0, 0,     0,  1, 0, 0, 0, 32'h1220,     0, 0,     0));
    tbl.push_back(mk(1, A, 0, 1, 4, 5'h11, DA, 1, 0, 0, 0, 32'h1220,     0, 0,     0));
    tbl.push_back(mk(1, A, 0, 0, 0, 0,     0,  1, 0, 1, 0, 32'h1220,     4, 5'h11, DA));
    tbl.push_back(mk(0, A, 0, 0, 0, 0,     0,  0, 0, 0, 0, 32'h0,        0, 0,     0));
    // flush one cycle after the strobe kills the return
    tbl.push_back(mk(1, B, 0, 0, 0, 0,     0,  0, 0, 0, 0, 32'h0,        0, 0,     0));
    tbl.push_back(mk(1, B, 0, 0, 0, 0,     0,  1, 1, 0, 0, 32'h2460,     0, 0,     0));
    tbl.push_back(mk(1, B, 1, 0, 0, 0,     0,  1, 0, 0, 0, 32'h2460,     0, 0,     0));
    tbl.push_back(mk(1, B, 0, 1, 9, 5'h03, DB, 1, 0, 0, 0, 32'h2460,     0, 0,     0));
    tbl.push_back(mk(0, B, 0, 0, 0, 0,     0,  0, 0, 0, 0, 32'h0,        0, 0,     0));
    // ready while idle is ignored
    tbl.push_back(mk(0, B, 0, 1, 9, 5'h03, DB, 0, 0, 0, 0, 32'h0,        0, 0,     0));
    tbl.push_back(mk(0, B, 0, 0, 0, 0,     0,  0, 0, 0, 0, 32'h0,        0, 0,     0));
    // flush during FILL does not stop the write
    tbl.push_back(mk(1, B, 0, 0, 0, 0,     0,  0, 0, 0, 0, 32'h0,        0, 0,     0));
    tbl.push_back(mk(1, B, 0, 0, 0, 0,     0,  1, 1, 0, 0, 32'h2460,     0, 0,     0));
    tbl.push_back(mk(1, B, 0, 0, 0, 0,     0,  1, 0, 0, 0, 32'h2460,     0, 0,     0));
    tbl.push_back(mk(1, B, 0, 1, 9, 5'h03, DB, 1, 0, 0, 0, 32'h2460,     0, 0,     0));
    tbl.push_back(mk(1, B, 1, 0, 0, 0,     0,  1, 0, 1, 0, 32'h2460,     9, 5'h03, DB));
    tbl.push_back(mk(0, B, 0, 0, 0, 0,     0,  0, 0, 0, 0, 32'h0,        0, 0,     0));
    // index mismatch: sticky error, no fill
    tbl.push_back(mk(1, A, 0, 0, 0, 0,     0,  0, 0, 0, 0, 32'h0,        0, 0,     0));
    tbl.push_back(mk(1, A, 0, 0, 0, 0,     0,  1, 1, 0, 0, 32'h1220,     0, 0,     0));
    tbl.push_back(mk(1, A, 0, 1, 4, 5'h12, DA, 1, 0, 0, 0, 32'h1220,     0, 0,     0));
    tbl.push_back(mk(0, A, 0, 0, 0, 0,     0,  0, 0, 0, 1, 32'h0,        0, 0,     0));
    tbl.push_back(mk(0, A, 0, 0, 0, 0,     0,  0, 0, 0, 1, 32'h0,        0, 0,     0));

    // Reset state, asserted from time zero
    #2;
    chk("reset busy", busy_o, 0);
    chk("reset re", mem_re0_o, 0);
    chk("reset fill", fill_valid_o, 0);
    chk("reset err", err_o, 0);
    chk("reset addr", mem_addr0_o, 0);
    step();
    reset = 1'b1;
    step();

    foreach (tbl[i]) begin
      miss_i = tbl[i].miss; miss_addr_i = tbl[i].addr; flush_i = tbl[i].flush;
      mem_data_ready0_i = tbl[i].ready; mem_tag0_i = tbl[i].rtag;
      mem_index0_i = tbl[i].ridx; mem_data0_i = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d busy", i), busy_o, tbl[i].busy);
      chk($sformatf("v%0d re", i), mem_re0_o, tbl[i].re);
      chk($sformatf("v%0d fill", i), fill_valid_o, tbl[i].fill);
      chk($sformatf("v%0d err", i), err_o, tbl[i].err);
      chk($sformatf("v%0d addr", i), mem_addr0_o, tbl[i].maddr);
      if (tbl[i].fill) begin
        chk($sformatf("v%0d ftag", i), fill_tag_o, tbl[i].ftag);
        chk($sformatf("v%0d fidx", i), fill_index_o, tbl[i].fidx);
        chk($sformatf("v%0d fdata", i), fill_data_o, tbl[i].fdata);
      end
      step();
    end
    idle_inputs();

    // Asynchronous reset clears the sticky error without a clock edge
    reset = 1'b0;
    #1;
    chk("async err clear", err_o, 0);
    step();
    reset = 1'b1;
    step();

    // Timeout re-issue to the same address, then a single fill
    p1 = -1; p2 = -1; pulses = 0; fills = 0;
    miss_addr_i = A;
    for (int cyc = 0; cyc < 40; cyc++) begin
      miss_i = (fills == 0);
      mem_data_ready0_i = (p2 >= 0) && (cyc == p2 + 1);
      mem_tag0_i = 21'd4; mem_index0_i = 5'h11; mem_data0_i = DA;
      #1;
      if (mem_re0_o) begin
        pulses++;
        if (p1 < 0) p1 = cyc;
        else if (p2 < 0) begin
          p2 = cyc;
          chk("timeout reissue addr", mem_addr0_o, 32'h1220);
        end
      end
      if (fill_valid_o) fills++;
      if (p1 >= 0 && fills > 0 && !busy_o) break;
      step();
    end
    chk("timeout pulses", pulses, 2);
    chk("timeout gap", p2 - p1, TO + 1);
    chk("timeout fills", fills, 1);
    chk("timeout ftag", fill_tag_o, 4);
    idle_inputs();
    step();

    // Reset mid-WAIT, then a late matching return
    miss_i = 1'b1; miss_addr_i = B;
    step(); step(); step();
    chk("midwait busy", busy_o, 1);
    reset = 1'b0;
    #1;
    chk("rst busy", busy_o, 0);
    chk("rst re", mem_re0_o, 0);
    chk("rst addr", mem_addr0_o, 0);
    chk("rst ftag", fill_tag_o, 0);
    chk("rst fidx", fill_index_o, 0);
    chk("rst fdata", fill_data_o, 0);
    miss_i = 1'b0;
    step();
    reset = 1'b1;
    mem_data_ready0_i = 1'b1; mem_tag0_i = 21'd9; mem_index0_i = 5'h03; mem_data0_i = DB;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("late fill %0d", k), fill_valid_o, 0);
      chk($sformatf("late busy %0d", k), busy_o, 0);
      step();
    end
    chk("late ftag", fill_tag_o, 0);
    chk("late addr", mem_addr0_o, 0);
    idle_inputs();
    step();

    // Freeze during REQ: strobe held back, then issued exactly once
    pulses = 0;
    miss_i = 1'b1; miss_addr_i = A;
    #1;
    chk("frz idle re", mem_re0_o, 0);
    step();
    run_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("frz re %0d", k), mem_re0_o, 0);
      chk($sformatf("frz busy %0d", k), busy_o, 1);
      step();
    end
    run_i = 1'b1;
    #1;
    if (mem_re0_o) pulses++;
    chk("frz resume addr", mem_addr0_o, 32'h1220);
    step();
    mem_data_ready0_i = 1'b1; mem_tag0_i = 21'd4; mem_index0_i = 5'h11; mem_data0_i = DA;
    #1;
    if (mem_re0_o) pulses++;
    chk("frz pulses", pulses, 1);
    step();
    mem_data_ready0_i = 1'b0;
    #1;
    chk("frz fill", fill_valid_o, 1);
    chk("frz fdata", fill_data_o, DA);
    step();
    miss_i = 1'b0;
    #1;
    chk("frz done busy", busy_o, 0);
`ifdef ICACHE_MISS_STATS_EN
    chk("stats miss count", miss_count_o, 1);
    chk("stats stall cycles", stall_cycles_o, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
